pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives enable and flush for the PC and the four pipeline latches: fetch (IF/ID), decode (ID/EX), execute (EX/MEM) and memory (MEM/WB). Resolves memory waits, load-use hazards and branch/jump redirects, and runs a halt-drain FSM. Keeps saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter
REG_W, 5, register-select width for hazard compare

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN, mem_dWEN  in  1 each  MEM-stage data read/write request
mem_redirect  in  1  branch taken or jump resolved in MEM; PC loads target
ex_dREN  in  1  EX-stage instruction is a load
ex_wsel  in  REG_W  EX-stage destination register
id_rs, id_rt  in  REG_W  ID-stage source registers
id_uses_rt  in  1  ID instruction reads rt
id_halt  in  1  halt decoded in ID
wb_halt  in  1  halt present at MEM/WB output
pc_en  out  1  PC update enable
fl_en, fl_flush  out  1 each  fetch latch control
dl_en, dl_flush  out  1 each  decode latch control
xl_en, xl_flush  out  1 each  execute latch control
ml_en, ml_flush  out  1 each  memory latch control
halted  out  1  pipeline halted
cyc_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset: state RUN. All counters 0. halted=0. All flush=0. All en=1. pc_en=1.
- Latch control outputs are combinational (Mealy) from inputs and state. At each latch, flush overrides en.
- FSM states: RUN, DRAIN, HALTED.
- RUN priority per cycle, highest first:
  1. dstall = (mem_dREN|mem_dWEN) & !dhit. pc_en, fl_en, dl_en, xl_en = 0. ml_flush=1, which inserts a WB bubble. mem_redirect is ignored and must hold, because EX/MEM is frozen.
  2. mem_redirect. pc_en=1 regardless of ihit (any pending fetch is abandoned). fl_flush, dl_flush, xl_flush = 1.
  3. load-use = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)). pc_en=0, fl_en=0, dl_flush=1.
  4. !ihit. pc_en=0, fl_flush=1. Downstream latches advance.
  5. Otherwise all en=1, no flush.
- RUN->DRAIN when id_halt is set and no case 1-3 applies. pc_en=0 from that cycle on. fl_flush=1 every cycle in DRAIN.
- In DRAIN, cases 1-3 still apply to the downstream latches.
- DRAIN + mem_redirect (not dstall): the halt was younger than the redirect and is squashed. Apply case 2 and return to RUN.
- DRAIN->HALTED when wb_halt=1. In HALTED all en=0, all flush=0, pc_en=0, halted=1. HALTED is left only by reset.
- Counters:
  - cyc_cnt increments every cycle except in HALTED.
  - stall_cnt increments on any RUN/DRAIN cycle in which case 1, 3 or 4 applies.
  - flush_cnt increments on each case-2 cycle.
  - All counters saturate at all-ones and never wrap.
- Asynchronous reset mid-stall or mid-drain immediately returns every output to its reset value.

Decomposition:
- cpu_types_pkg gains:
  - pipe_state_t enum {RUN, DRAIN, HALTED}
  - latch_ctrl_t packed struct {en, flush}
- Sub-module sat_counter (CNT_W parameter, inc input), instantiated three times.
- Load-use compare stays inline.

Test Plan:
- Reset, then ihit=1 and no hazards -> all en=1, flush=0, pc_en=1; after 10 cycles cyc_cnt=10, stall_cnt=0.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> pc_en, fl_en, dl_en, xl_en=0 and ml_flush=1 for 3 cycles, then all en=1; stall_cnt=3.
- ex_dREN=1, ex_wsel=5, id_rt=5, id_uses_rt=1 -> pc_en=0, fl_en=0, dl_flush=1. Repeat with ex_wsel=0 -> no stall.
- mem_redirect=1 with ihit=0 -> pc_en=1 and fl/dl/xl_flush=1; flush_cnt increments by 1.
- id_halt=1, then wb_halt=1 three cycles later -> DRAIN with pc_en=0, then HALTED with halted=1 and cyc_cnt frozen. Repeat with mem_redirect during DRAIN -> returns to RUN and halted stays 0.
- Preload stall_cnt near all-ones (force) and stall -> stall_cnt holds at all-ones. Assert nRST mid-DRAIN -> counters 0, state RUN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types: sequencer state and per-latch enable/flush pair.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Performance counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with halt-drain FSM and perf counters.
// Latch controls are Mealy outputs; reset forces them to their idle values immediately.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             fl_en,
  output logic             fl_flush,
  output logic             dl_en,
  output logic             dl_flush,
  output logic             xl_en,
  output logic             xl_flush,
  output logic             ml_en,
  output logic             ml_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_t state, next_state;
  latch_ctrl_t fl, dl, xl, ml;
  logic        pc_en_c;
  logic        dstall, load_use;
  logic        stall_inc, flush_inc, cyc_inc;

  assign dstall   = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = ex_dREN && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_en_c    = 1'b1;
    fl         = '{en: 1'b1, flush: 1'b0};
    dl         = '{en: 1'b1, flush: 1'b0};
    xl         = '{en: 1'b1, flush: 1'b0};
    ml         = '{en: 1'b1, flush: 1'b0};
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    cyc_inc    = 1'b0;

    if (nRST) begin
      unique case (state)
        RUN, DRAIN: begin
          cyc_inc = 1'b1;
          // EX/MEM is frozen during a data stall, so a pending redirect waits behind it
          if (dstall) begin
            pc_en_c   = 1'b0;
            fl.en     = 1'b0;
            dl.en     = 1'b0;
            xl.en     = 1'b0;
            ml.flush  = 1'b1;
            stall_inc = 1'b1;
          end else if (mem_redirect) begin
            pc_en_c   = 1'b1;
            fl.flush  = 1'b1;
            dl.flush  = 1'b1;
            xl.flush  = 1'b1;
            flush_inc = 1'b1;
          end else if (load_use) begin
            pc_en_c   = 1'b0;
            fl.en     = 1'b0;
            dl.flush  = 1'b1;
            stall_inc = 1'b1;
          end else if (!ihit) begin
            pc_en_c   = 1'b0;
            fl.flush  = 1'b1;
            stall_inc = 1'b1;
          end

          if (state == RUN) begin
            if (id_halt && !dstall && !mem_redirect && !load_use) begin
              next_state = DRAIN;
              pc_en_c    = 1'b0;
              fl.flush   = 1'b1;
            end
          end else begin
            // A redirect in DRAIN squashes the younger halt and resumes fetching
            if (!flush_inc) begin
              pc_en_c  = 1'b0;
              fl.flush = 1'b1;
            end
            if (wb_halt) begin
              next_state = HALTED;
            end else if (flush_inc) begin
              next_state = RUN;
            end
          end
        end
        HALTED: begin
          pc_en_c = 1'b0;
          fl      = '{en: 1'b0, flush: 1'b0};
          dl      = '{en: 1'b0, flush: 1'b0};
          xl      = '{en: 1'b0, flush: 1'b0};
          ml      = '{en: 1'b0, flush: 1'b0};
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign pc_en    = pc_en_c;
  assign fl_en    = fl.en;
  assign fl_flush = fl.flush;
  assign dl_en    = dl.en;
  assign dl_flush = dl.flush;
  assign xl_en    = xl.en;
  assign xl_flush = xl.flush;
  assign ml_en    = ml.en;
  assign ml_flush = ml.flush;
  assign halted   = (state == HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (cyc_inc),
    .cnt  (cyc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard priorities, halt/drain FSM, counters and async reset.
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;
  localparam int REG_W = 5;

  logic             CLK;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, ex_dREN;
  logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
  logic             id_uses_rt, id_halt, wb_halt;
  logic             pc_en, fl_en, fl_flush, dl_en, dl_flush;
  logic             xl_en, xl_flush, ml_en, ml_flush, halted;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;
  logic [8:0]       ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] CTL_RUN = 9'b1_10_10_10_10;
  localparam logic [8:0] M_ALL   = 9'b1_11_11_11_11;

  pipeline_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .wb_halt(wb_halt),
    .pc_en(pc_en), .fl_en(fl_en), .fl_flush(fl_flush), .dl_en(dl_en), .dl_flush(dl_flush),
    .xl_en(xl_en), .xl_flush(xl_flush), .ml_en(ml_en), .ml_flush(ml_flush),
    .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_en, fl_en, fl_flush, dl_en, dl_flush, xl_en, xl_flush, ml_en, ml_flush}
  assign ctl = {pc_en, fl_en, fl_flush, dl_en, dl_flush, xl_en, xl_flush, ml_en, ml_flush};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_redirect = 1'b0; ex_dREN = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; id_halt = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #2;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_RUN); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if ({cyc_cnt, stall_cnt, flush_cnt} !== '0) begin errors++; $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0", cyc_cnt, stall_cnt, flush_cnt); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_normal();
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL normal_ctl got %b want %b", ctl, CTL_RUN); end
    repeat (10) @(negedge CLK);
    checks++; if (cyc_cnt !== 32'd10) begin errors++; $display("FAIL normal_cyc got %0d want 10", cyc_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL normal_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_dstall();
    @(negedge CLK);
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ((ctl & 9'b1_11_11_11_01) !== 9'b0_00_00_00_01) begin errors++; $display("FAIL dstall_ctl[%0d] got %b want 0000000x1", i, ctl); end
      @(negedge CLK);
    end
    dhit = 1'b1;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL dstall_release got %b want %b", ctl, CTL_RUN); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL dstall_cnt got %0d want 3", stall_cnt); end
    @(negedge CLK);
    mem_dREN = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    ex_dREN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
    #1;
    checks++; if ((ctl & 9'b1_10_01_00_00) !== 9'b0_00_01_00_00) begin errors++; $display("FAIL lu_rt_ctl got %b want pc0 fl_en0 dl_flush1", ctl); end
    @(negedge CLK);
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL lu_rt_cnt got %0d want 4", stall_cnt); end
    ex_wsel = 5'd0; id_rt = 5'd0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_r0_ctl got %b want %b", ctl, CTL_RUN); end
    @(negedge CLK);
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL lu_r0_cnt got %0d want 4", stall_cnt); end
    ex_wsel = 5'd7; id_rs = 5'd7; id_rt = 5'd0; id_uses_rt = 1'b0;
    #1;
    checks++; if ((ctl & 9'b1_10_01_00_00) !== 9'b0_00_01_00_00) begin errors++; $display("FAIL lu_rs_ctl got %b want pc0 fl_en0 dl_flush1", ctl); end
    @(negedge CLK);
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL lu_rs_cnt got %0d want 5", stall_cnt); end
    id_rs = 5'd0; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_rt_unused got %b want %b", ctl, CTL_RUN); end
    @(negedge CLK);
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL lu_rt_unused_cnt got %0d want 5", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_redirect();
    @(negedge CLK);
    mem_redirect = 1'b1; ihit = 1'b0;
    #1;
    checks++; if ((ctl & 9'b1_01_01_01_00) !== 9'b1_01_01_01_00) begin errors++; $display("FAIL redirect_ctl got %b want pc1 fl/dl/xl_flush1", ctl); end
    @(negedge CLK);
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL redirect_cnt got %0d want 1", flush_cnt); end
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL redirect_stall got %0d want 5", stall_cnt); end
    mem_dREN = 1'b1; dhit = 1'b0;
    #1;
    checks++; if ((ctl & 9'b1_11_11_11_01) !== 9'b0_00_00_00_01) begin errors++; $display("FAIL dstall_over_redirect got %b want 0000000x1", ctl); end
    @(negedge CLK);
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL dstall_over_redirect_flush got %0d want 1", flush_cnt); end
    checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL dstall_over_redirect_stall got %0d want 6", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    @(negedge CLK);
    force dut.u_stall_cnt.cnt = 32'hFFFF_FFFD;
    #1;
    release dut.u_stall_cnt.cnt;
    ihit = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stall_saturate got %h want ffffffff", stall_cnt); end
    @(negedge CLK);
    checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stall_hold got %h want ffffffff", stall_cnt); end
    ihit = 1'b1;
  endtask

  task automatic test_halt();
    do_reset();
    id_halt = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL halt_enter_pc got %b want 0", pc_en); end
    @(negedge CLK);
    id_halt = 1'b0;
    #1;
    checks++; if ((ctl & 9'b1_01_00_00_00) !== 9'b0_01_00_00_00) begin errors++; $display("FAIL drain_ctl got %b want pc0 fl_flush1", ctl); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_halted got %b want 0", halted); end
    repeat (2) @(negedge CLK);
    wb_halt = 1'b1;
    #1;
    checks++; if ((ctl & 9'b1_01_00_00_00) !== 9'b0_01_00_00_00) begin errors++; $display("FAIL drain_late_ctl got %b want pc0 fl_flush1", ctl); end
    @(negedge CLK);
    wb_halt = 1'b0;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted got %b want 1", halted); end
    checks++; if (ctl !== 9'b0) begin errors++; $display("FAIL halted_ctl got %b want 000000000", ctl); end
    checks++; if (cyc_cnt !== 32'd4) begin errors++; $display("FAIL halted_cyc got %0d want 4", cyc_cnt); end
    repeat (5) @(negedge CLK);
    checks++; if (cyc_cnt !== 32'd4) begin errors++; $display("FAIL halted_cyc_frozen got %0d want 4", cyc_cnt); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky got %b want 1", halted); end
  endtask

  task automatic test_halt_redirect();
    do_reset();
    id_halt = 1'b1;
    @(negedge CLK);
    id_halt = 1'b0; mem_redirect = 1'b1;
    #1;
    checks++; if ((ctl & 9'b1_01_01_01_00) !== 9'b1_01_01_01_00) begin errors++; $display("FAIL drain_redirect_ctl got %b want pc1 fl/dl/xl_flush1", ctl); end
    @(negedge CLK);
    mem_redirect = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL drain_redirect_run got %b want %b", ctl, CTL_RUN); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL drain_redirect_flush got %0d want 1", flush_cnt); end
    checks++; if (cyc_cnt !== 32'd2) begin errors++; $display("FAIL drain_redirect_cyc got %0d want 2", cyc_cnt); end
    wb_halt = 1'b1;
    @(negedge CLK);
    wb_halt = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_redirect_halted got %b want 0", halted); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    id_halt = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    id_halt = 1'b0;
    @(negedge CLK);
    checks++; if (cyc_cnt !== 32'd2) begin errors++; $display("FAIL mid_drain_cyc got %0d want 2", cyc_cnt); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL async_reset_ctl got %b want %b", ctl, CTL_RUN); end
    checks++; if ({cyc_cnt, stall_cnt, flush_cnt} !== '0) begin errors++; $display("FAIL async_reset_cnt got %0d %0d %0d want 0 0 0", cyc_cnt, stall_cnt, flush_cnt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_reset_halted got %b want 0", halted); end
    ihit = 1'b1;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL post_reset_run got %b want %b", ctl, CTL_RUN); end
    @(negedge CLK);
    #1;
    checks++; if ((ctl & M_ALL) !== CTL_RUN) begin errors++; $display("FAIL post_reset_state got %b want %b", ctl, CTL_RUN); end
    checks++; if (cyc_cnt !== 32'd1) begin errors++; $display("FAIL post_reset_cyc got %0d want 1", cyc_cnt); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_dstall();
    test_load_use();
    test_redirect();
    test_saturate();
    test_halt();
    test_halt_redirect();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
